mem_dump_reader: RTL and testbench
==================================

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000, is the number of stable clk cycles required before a step-button level is accepted.
REQ-002 Parameter ADDR_W, default 8, is the data-memory address width.
REQ-003 Parameter DATA_W, default 16, is the data-memory word width.
REQ-004 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 step  input  1  raw, unsynchronised step push-button, active-high.
REQ-007 run  input  1  level signal; 1 = CPU owns data memory, 0 = reader may own it.
REQ-008 cpu_addr / cpu_we / cpu_wdata  input  ADDR_W / 1 / DATA_W  CPU-side data-memory request.
REQ-009 mem_addr / mem_we / mem_wdata  output  ADDR_W / 1 / DATA_W  muxed request to data memory.
REQ-010 mem_rdata  input  DATA_W  data-memory read data, valid exactly 1 cycle after mem_addr is presented.
REQ-011 show_addr  output  ADDR_W  address of the word on display.
REQ-012 show_data  output  DATA_W  captured memory word for the seven-segment driver.
REQ-013 valid  output  1  high while show_data matches show_addr.
REQ-014 busy  output  1  high while a reader access is in flight (states GRANT, READ, CAPTURE).

Function
REQ-015 step is passed through a 2-flop synchroniser, then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
REQ-016 A rising edge of the debounced level produces exactly one 1-cycle step_pulse; holding the button yields no further pulses.
REQ-017 FSM states: IDLE, GRANT, READ, CAPTURE, SHOW.
REQ-018 IDLE: mem_* follow cpu_* combinationally; valid=0; on run=0 go to GRANT.
REQ-019 GRANT: mem_we forced 0, mem_addr=cur_addr, mem_wdata=0; next cycle go to READ.
REQ-020 READ: mem_addr=cur_addr held, mem_we=0; next cycle go to CAPTURE.
REQ-021 CAPTURE: show_data<=mem_rdata, show_addr<=cur_addr, valid<=1; go to SHOW.
REQ-022 SHOW: mem_we=0; on step_pulse cur_addr<=cur_addr+1 modulo 2^ADDR_W (255 wraps to 0), valid<=0, go to GRANT.
REQ-023 In any state other than IDLE, run=1 forces a transition to IDLE on the next edge, valid<=0; mem_* return to cpu_* in that same cycle (combinational on run), so the CPU never sees a lost write.
REQ-024 A step_pulse arriving in GRANT/READ/CAPTURE is ignored (not queued).
REQ-025 In IDLE cur_addr is retained; re-entering via run=0 re-reads the same address.
REQ-026 Reader never asserts mem_we; cpu_we is forwarded only when mux selects the CPU.

Reset
REQ-027 reset=0 asynchronously sets state=IDLE, cur_addr=0, show_addr=0, show_data=0, valid=0, busy=0, debounce counter=0, debounced level=0, synchroniser flops=0.
REQ-028 After reset release, the first step_pulse requires DEBOUNCE_CYCLES+2 cycles of step=1.
REQ-029 Reset asserted mid-read aborts without any mem_we pulse.

Structure
REQ-030 State encoding (IDLE..SHOW) and DEBOUNCE_CYCLES default reside in the shared CPU-board package.
REQ-031 The synchroniser, debounce and edge detector form one sub-module, btn_pulse, reusable for the other front-panel buttons.
REQ-032 The FSM, address counter, capture registers and port mux stay in mem_dump_reader.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-033 run=0, memory[0]=16'hBEEF, after reset -> GRANT, READ, CAPTURE in 3 cycles; show_addr=0, show_data=16'hBEEF, valid=1.
REQ-034 In SHOW, step=1 held 20 cycles -> exactly one step_pulse; show_addr=1, show_data=memory[1], mem_we=0 throughout.
REQ-035 cur_addr=8'hFF, step press -> show_addr=8'h00, show_data=memory[0].
REQ-036 step glitch 1 cycle high, 3 low, repeated -> no step_pulse, show_addr unchanged.
REQ-037 run rises during READ with cpu_we=1, cpu_addr=8'h10, cpu_wdata=16'h1234 -> mem_we=1, mem_addr=8'h10 that cycle; memory[0x10]=16'h1234; valid=0; state IDLE.
REQ-038 reset pulsed low during CAPTURE -> all outputs 0 immediately, no write to memory, valid=0.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// Shared CPU-board definitions: reader FSM encoding and front-panel
// button debounce default.
package mem_dump_reader_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 5000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_READ,
      S_CAPTURE,
      S_SHOW
   } state_t;

endpackage

// File: rtl/mem_dump_reader_btn_pulse.sv
// Front-panel button conditioner: 2-flop synchroniser, debounce,
// and rising-edge one-shot.
module btn_pulse
   import mem_dump_reader_pkg::*;
#(
   parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = $clog2(CYCLES + 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_lvl;
   logic          r_lvl_d;
   logic [CW-1:0] r_cnt;

   // Counter tracks consecutive samples that disagree with the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_lvl   <= 1'b0;
         r_lvl_d <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_lvl_d <= r_lvl;
         if (r_s2 == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(CYCLES - 1)) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_pulse = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/mem_dump_reader.sv
// Front-panel data-memory dump reader: steals the memory port while
// the CPU is halted and shows one word per step press.
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int ADDR_W          = 8,
   parameter int DATA_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step,
   input  logic              run,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] show_addr,
   output logic [DATA_W-1:0] show_data,
   output logic              valid,
   output logic              busy
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [ADDR_W-1:0] r_show_addr;
   logic [DATA_W-1:0] r_show_data;
   logic              r_valid;
   logic              w_step_pulse;
   logic              w_cpu_sel;
   logic              w_abort;

   btn_pulse #(
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst_n   (reset),
      .i_btn   (step),
      .o_pulse (w_step_pulse)
   );

   assign w_abort = (r_state != S_IDLE) && run;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:    if (!run) w_next = S_GRANT;
            S_GRANT:   w_next = S_READ;
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SHOW;
            S_SHOW:    if (w_step_pulse) w_next = S_GRANT;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cur_addr  <= '0;
         r_show_addr <= '0;
         r_show_data <= '0;
         r_valid     <= 1'b0;
      end else if (w_abort) begin
         r_valid <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
         r_show_data <= mem_rdata;
         r_show_addr <= r_cur_addr;
         r_valid     <= 1'b1;
      end else if (r_state == S_SHOW && w_step_pulse) begin
         r_cur_addr <= r_cur_addr + ADDR_W'(1);
         r_valid    <= 1'b0;
      end
   end

   // run is in the select so the CPU regains the port the same cycle.
   always_comb begin
      w_cpu_sel = (r_state == S_IDLE) || run;
      mem_addr  = w_cpu_sel ? cpu_addr  : r_cur_addr;
      mem_we    = w_cpu_sel ? cpu_we    : 1'b0;
      mem_wdata = w_cpu_sel ? cpu_wdata : '0;
      busy      = (r_state == S_GRANT) ||
                  (r_state == S_READ)  ||
                  (r_state == S_CAPTURE);
   end

   assign show_addr = r_show_addr;
   assign show_data = r_show_data;
   assign valid     = r_valid;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader with a synchronous RAM model
// and an address/contents reference model.
module tb_mem_dump_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        step;
   logic        run;
   logic [7:0]  cpu_addr;
   logic        cpu_we;
   logic [15:0] cpu_wdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [7:0]  show_addr;
   logic [15:0] show_data;
   logic        valid;
   logic        busy;

   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   logic        load;
   logic [7:0]  m_addr;
   int          n_chk = 0;
   int          n_err = 0;
   int          n_fall = 0;
   int          bad_we = 0;
   logic        prev_valid = 1'b0;

   typedef struct {
      logic [7:0]  a;
      logic        we;
      logic [15:0] d;
      logic [7:0]  ea;
      logic        ewe;
      logic [15:0] ed;
   } vec_t;

   vec_t vt [6];

   mem_dump_reader #(
      .DEBOUNCE_CYCLES (4),
      .ADDR_W          (8),
      .DATA_W          (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .run       (run),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .show_addr (show_addr),
      .show_data (show_data),
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   always @(negedge clk) begin
      if (prev_valid && !valid) n_fall++;
      prev_valid = valid;
      if (mem_we && !cpu_we) bad_we++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string nm);
      int k = 0;
      while (!valid && k < 30) begin
         tick();
         k++;
      end
      chk({nm, " valid"}, {31'd0, valid}, 32'd1);
   endtask

   task automatic press(input int hold);
      step = 1'b1;
      repeat (hold) tick();
      step = 1'b0;
      repeat (10) tick();
   endtask

   task automatic chk_show(input string nm);
      wait_valid(nm);
      chk({nm, " addr"}, {24'd0, show_addr}, {24'd0, m_addr});
      chk({nm, " data"}, {16'd0, show_data}, {16'd0, ref_mem[m_addr]});
   endtask

   initial begin
      reset     = 1'b0;
      step      = 1'b0;
      run       = 1'b1;
      cpu_addr  = '0;
      cpu_we    = 1'b0;
      cpu_wdata = '0;
      load      = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
      ref_mem[0] = 16'hBEEF;

      vt[0] = '{8'h05, 1'b0, 16'h0000, 8'h05, 1'b0, 16'h0000};
      vt[1] = '{8'h30, 1'b1, 16'hCAFE, 8'h30, 1'b1, 16'hCAFE};
      vt[2] = '{8'hFF, 1'b1, 16'h0FF0, 8'hFF, 1'b1, 16'h0FF0};
      vt[3] = '{8'h80, 1'b0, 16'hFFFF, 8'h80, 1'b0, 16'hFFFF};
      vt[4] = '{8'h7F, 1'b1, 16'h1357, 8'h7F, 1'b1, 16'h1357};
      vt[5] = '{8'hA5, 1'b0, 16'h5A5A, 8'hA5, 1'b0, 16'h5A5A};

      repeat (2) tick();
      load = 1'b0;
      chk("rst show_addr", {24'd0, show_addr}, 32'd0);
      chk("rst show_data", {16'd0, show_data}, 32'd0);
      chk("rst valid", {31'd0, valid}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);

      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         cpu_addr  = vt[i].a;
         cpu_we    = vt[i].we;
         cpu_wdata = vt[i].d;
         #1;
         chk($sformatf("mux%0d addr", i), {24'd0, mem_addr}, {24'd0, vt[i].ea});
         chk($sformatf("mux%0d we", i), {31'd0, mem_we}, {31'd0, vt[i].ewe});
         chk($sformatf("mux%0d wdata", i), {16'd0, mem_wdata}, {16'd0, vt[i].ed});
         tick();
         if (vt[i].we) ref_mem[vt[i].a] = vt[i].d;
         cpu_we = 1'b0;
      end
      chk("idle valid", {31'd0, valid}, 32'd0);

      // first read of word 0 after a fresh reset
      reset = 1'b0;
      tick();
      run   = 1'b0;
      reset = 1'b1;
      m_addr = 8'h00;
      chk_show("first");
      chk("first data BEEF", {16'd0, show_data}, 32'h0000BEEF);
      chk("first busy", {31'd0, busy}, 32'd0);

      n_fall = 0;
      press(20);
      m_addr = m_addr + 8'd1;
      chk_show("hold20");
      chk("hold20 pulses", n_fall, 32'd1);

      n_fall = 0;
      repeat (5) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         repeat (3) tick();
      end
      repeat (8) tick();
      chk("glitch pulses", n_fall, 32'd0);
      chk_show("glitch");

      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            press($urandom_range(7, 12));
            m_addr = m_addr + 8'd1;
         end else begin
            run       = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 8'($urandom);
            cpu_wdata = 16'($urandom);
            tick();
            ref_mem[cpu_addr] = cpu_wdata;
            chk("cpu op valid", {31'd0, valid}, 32'd0);
            cpu_we = 1'b0;
            run    = 1'b0;
         end
         chk_show($sformatf("rand%0d", it));
      end

      for (int g = 0; g < 300 && m_addr != 8'hFF; g++) begin
         press(8);
         m_addr = m_addr + 8'd1;
      end
      chk_show("addr FF");
      press(8);
      m_addr = m_addr + 8'd1;
      chk_show("wrap");
      chk("wrap addr 00", {24'd0, show_addr}, 32'd0);

      run = 1'b1;
      tick();
      chk("to idle valid", {31'd0, valid}, 32'd0);
      run = 1'b0;
      tick();
      tick();
      chk("in read busy", {31'd0, busy}, 32'd1);
      run       = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 8'h10;
      cpu_wdata = 16'h1234;
      #1;
      chk("steal we", {31'd0, mem_we}, 32'd1);
      chk("steal addr", {24'd0, mem_addr}, 32'h10);
      chk("steal wdata", {16'd0, mem_wdata}, 32'h1234);
      tick();
      cpu_we = 1'b0;
      ref_mem[8'h10] = 16'h1234;
      chk("steal mem", {16'd0, mem[8'h10]}, 32'h1234);
      chk("steal valid", {31'd0, valid}, 32'd0);
      chk("steal busy", {31'd0, busy}, 32'd0);

      run = 1'b0;
      repeat (3) tick();
      chk("capture busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort show_addr", {24'd0, show_addr}, 32'd0);
      chk("abort show_data", {16'd0, show_data}, 32'd0);
      chk("abort valid", {31'd0, valid}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort we", {31'd0, mem_we}, 32'd0);
      repeat (3) tick();
      reset  = 1'b1;
      m_addr = 8'h00;
      chk_show("after abort");

      chk("reader writes", bad_we, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
